// File: rtl/mips_program_loader_if.sv
// Byte-stream input and memory write port of the MIPS program loader.
// Handshake: in_data is transferred on a clk1 rising edge where in_valid && in_ready are both high.
// The source holds in_data stable while in_valid is high and in_ready is low.
// The memory side has no back-pressure. One mem_we pulse writes one word.
interface mips_program_loader_if #(
  parameter int ADDR_W = 10
);
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  // Byte source and memory sink
  modport master (
    output in_data, in_valid,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  // Loader
  modport slave (
    input  in_data, in_valid,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mips_program_loader.sv
// Byte-serial boot loader for the Pipelined_MIPS32 core.
// A frame has this layout: MAGIC, CNT_HI, CNT_LO, then N big-endian words, then an XOR checksum of the data bytes.
// The loader writes the words from BASE_ADDR upward and keeps the core halted.
// When the checksum matches, it releases the core with a one-cycle start pulse.
module mips_program_loader #(
  parameter int          ADDR_W    = 10,
  parameter int          BASE_ADDR = 0,
  parameter logic [7:0]  MAGIC     = 8'hA5
) (
  input  logic                 clk1,
  input  logic                 rst,
  mips_program_loader_if.slave bus,
  input  logic                 restart,
  output logic                 cpu_hold,
  output logic                 cpu_start,
  output logic                 load_done,
  output logic                 load_err,
  output logic [15:0]          words_loaded,
  output logic [2:0]           dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CNT_HI = 3'd1,
    S_CNT_LO = 3'd2,
    S_DATA   = 3'd3,
    S_CSUM   = 3'd4,
    S_DONE   = 3'd5,
    S_ERR    = 3'd6
  } state_t;

  // The largest word count that still fits between BASE_ADDR and the top of memory.
  localparam logic [31:0] MAX_N = (32'd1 << ADDR_W) - 32'(BASE_ADDR);

  state_t            state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              cpu_hold_q, cpu_hold_d;
  logic              cpu_start_q, cpu_start_d;
  logic              load_done_q, load_done_d;
  logic              load_err_q, load_err_d;
  logic [15:0]       words_q, words_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [7:0]        csum_q, csum_d;
  logic [31:0]       asm_q, asm_d;

  logic              hs;
  logic [15:0]       n_w;

  assign hs  = bus.in_valid && in_ready_q;
  assign n_w = {cnt_q[15:8], bus.in_data};

  // Compute the next state of the frame parser and the next values of all registered outputs.
  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_hold_d  = cpu_hold_q;
    cpu_start_d = 1'b0;
    load_done_d = load_done_q;
    load_err_d  = load_err_q;
    words_d     = words_q;
    cnt_d       = cnt_q;
    byte_idx_d  = byte_idx_q;
    csum_d      = csum_q;
    asm_d       = asm_q;

    case (state_q)
      S_IDLE: begin
        // Bytes other than MAGIC are consumed and dropped.
        if (hs && bus.in_data == MAGIC) begin
          state_d    = S_CNT_HI;
          words_d    = 16'd0;
          byte_idx_d = 2'd0;
          csum_d     = 8'd0;
          asm_d      = 32'd0;
        end
      end
      S_CNT_HI: begin
        if (hs) begin
          cnt_d[15:8] = bus.in_data;
          state_d     = S_CNT_LO;
        end
      end
      S_CNT_LO: begin
        if (hs) begin
          cnt_d[7:0] = bus.in_data;
          if (32'(n_w) > MAX_N) begin
            state_d    = S_ERR;
            in_ready_d = 1'b0;
            load_err_d = 1'b1;
          end else if (n_w == 16'd0) begin
            state_d = S_CSUM;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (hs) begin
          asm_d      = {asm_q[23:0], bus.in_data};
          csum_d     = csum_q ^ bus.in_data;
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            // The write shows up one cycle after the fourth byte. It uses the word index before the increment.
            mem_we_d    = 1'b1;
            mem_wdata_d = {asm_q[23:0], bus.in_data};
            mem_addr_d  = ADDR_W'(BASE_ADDR) + ADDR_W'(words_q);
            words_d     = words_q + 16'd1;
            if (words_q == cnt_q - 16'd1) begin
              state_d = S_CSUM;
            end
          end
        end
      end
      S_CSUM: begin
        if (hs) begin
          in_ready_d = 1'b0;
          if (bus.in_data == csum_q) begin
            state_d     = S_DONE;
            cpu_hold_d  = 1'b0;
            cpu_start_d = 1'b1;
            load_done_d = 1'b1;
          end else begin
            state_d    = S_ERR;
            load_err_d = 1'b1;
          end
        end
      end
      S_DONE, S_ERR: begin
        if (restart) begin
          state_d     = S_IDLE;
          in_ready_d  = 1'b1;
          cpu_hold_d  = 1'b1;
          load_done_d = 1'b0;
          load_err_d  = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Register the parser state and all outputs. Synchronous reset takes priority over restart.
  always_ff @(posedge clk1) begin
    if (rst) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= ADDR_W'(BASE_ADDR);
      mem_wdata_q <= 32'd0;
      cpu_hold_q  <= 1'b1;
      cpu_start_q <= 1'b0;
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;
      words_q     <= 16'd0;
      cnt_q       <= 16'd0;
      byte_idx_q  <= 2'd0;
      csum_q      <= 8'd0;
      asm_q       <= 32'd0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_hold_q  <= cpu_hold_d;
      cpu_start_q <= cpu_start_d;
      load_done_q <= load_done_d;
      load_err_q  <= load_err_d;
      words_q     <= words_d;
      cnt_q       <= cnt_d;
      byte_idx_q  <= byte_idx_d;
      csum_q      <= csum_d;
      asm_q       <= asm_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign cpu_hold      = cpu_hold_q;
  assign cpu_start     = cpu_start_q;
  assign load_done     = load_done_q;
  assign load_err      = load_err_q;
  assign words_loaded  = words_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_mips_program_loader.sv
// Testbench for mips_program_loader. It drives random byte frames and checks the memory writes and the start pulses.
module tb_mips_program_loader;
  localparam int ADDR_W = 10;
  localparam int BASE   = 0;
  localparam int MAX_N  = (1 << ADDR_W) - BASE;
  localparam int EW     = 32 + ADDR_W + 32;

  // ---------------- clock / reset ----------------
  logic        clk1 = 1'b0;
  logic        rst;
  logic        restart;
  logic        cpu_hold, cpu_start, load_done, load_err;
  logic [15:0] words_loaded;
  logic [2:0]  dbg_state;

  mips_program_loader_if #(.ADDR_W(ADDR_W)) bus ();

  mips_program_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE), .MAGIC(8'hA5)) dut (
    .clk1         (clk1),
    .rst          (rst),
    .bus          (bus.slave),
    .restart      (restart),
    .cpu_hold     (cpu_hold),
    .cpu_start    (cpu_start),
    .load_done    (load_done),
    .load_err     (load_err),
    .words_loaded (words_loaded),
    .dbg_state    (dbg_state)
  );

  always #5 clk1 = ~clk1;

  int unsigned cyc = 0;
  always @(posedge clk1) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, time=%0t required=finish", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [EW-1:0] exp_q[$];      // {handshake cycle, address, data}
  int unsigned   start_q[$];    // handshake cycle of each good checksum byte
  logic [31:0]   fixed_words[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  logic [EW-1:0] mon_e;
  // Monitor: every write and every start pulse must match the head of its expected queue.
  always @(negedge clk1) begin
    if (rst === 1'b0) begin
      if (bus.mem_we === 1'b1) begin
        if (exp_q.size() == 0) check("unexpected_mem_we", 32'd1, 32'd0);
        else begin
          mon_e = exp_q.pop_front();
          check("mem_we_cycle", cyc, mon_e[32+ADDR_W +: 32]);
          check("mem_addr", 32'(bus.mem_addr), 32'(mon_e[32 +: ADDR_W]));
          check("mem_wdata", bus.mem_wdata, mon_e[31:0]);
        end
      end
      if (cpu_start === 1'b1) begin
        if (start_q.size() == 0) check("unexpected_cpu_start", 32'd1, 32'd0);
        else begin
          check("cpu_start_cycle", cyc, start_q.pop_front());
          check("cpu_hold_at_start", 32'(cpu_hold), 32'd0);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk1);
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, output int unsigned hs_cyc);
    bit done;
    bit rdy;
    int k;
    done   = 1'b0;
    k      = 0;
    hs_cyc = 0;
    while (!done && k < 50) begin
      @(negedge clk1);
      bus.in_data  = b;
      bus.in_valid = 1'b1;
      rdy = bus.in_ready;
      @(posedge clk1);
      #1;
      if (rdy) begin
        done   = 1'b1;
        hs_cyc = cyc;
      end
      k++;
    end
    if (!done) check("in_ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"},  32'(bus.in_ready), 32'd1);
    check({tag, "_mem_we"},    32'(bus.mem_we), 32'd0);
    check({tag, "_mem_addr"},  32'(bus.mem_addr), 32'(BASE));
    check({tag, "_mem_wdata"}, bus.mem_wdata, 32'd0);
    check({tag, "_cpu_hold"},  32'(cpu_hold), 32'd1);
    check({tag, "_cpu_start"}, 32'(cpu_start), 32'd0);
    check({tag, "_load_done"}, 32'(load_done), 32'd0);
    check({tag, "_load_err"},  32'(load_err), 32'd0);
    check({tag, "_words"},     32'(words_loaded), 32'd0);
  endtask

  // Reference model: the frame is built from a list of words, and every write follows from the word index.
  // A count too large to fit in memory means no data is sent and the loader ends in the error state.
  task automatic run_frame(input int n, input bit bad, input int gap_pct, input int stall_at);
    logic [7:0]        cs;
    logic [7:0]        b;
    logic [31:0]       w;
    logic [ADDR_W-1:0] a;
    int unsigned       hc;
    bit                ok;
    cs = 8'd0;
    send_byte(8'hA5, hc);
    send_byte(n[15:8], hc);
    send_byte(n[7:0], hc);
    if (n > MAX_N) begin
      ok = 1'b0;
    end else begin
      for (int i = 0; i < n; i++) begin
        w = (i < fixed_words.size()) ? fixed_words[i] : $urandom;
        for (int j = 0; j < 4; j++) begin
          if (stall_at == i * 4 + j) idle(20);
          else if ($urandom_range(0, 99) < gap_pct) idle($urandom_range(1, 3));
          b  = w[31 - 8 * j -: 8];
          cs = cs ^ b;
          send_byte(b, hc);
        end
        a = ADDR_W'(BASE + i);
        exp_q.push_back({hc, a, w});
      end
      ok = !bad;
      send_byte(bad ? (cs ^ 8'h01) : cs, hc);
      if (ok) start_q.push_back(hc);
    end
    idle(3);
    check("frame_load_done", 32'(load_done), ok ? 32'd1 : 32'd0);
    check("frame_load_err",  32'(load_err),  ok ? 32'd0 : 32'd1);
    check("frame_cpu_hold",  32'(cpu_hold),  ok ? 32'd0 : 32'd1);
    check("frame_cpu_start_low", 32'(cpu_start), 32'd0);
    check("frame_in_ready",  32'(bus.in_ready), 32'd0);
    check("frame_words_loaded", 32'(words_loaded), (n > MAX_N) ? 32'd0 : 32'(n));
    check("frame_writes_drained", 32'(exp_q.size()), 32'd0);
    check("frame_starts_drained", 32'(start_q.size()), 32'd0);
  endtask

  task automatic do_restart();
    @(negedge clk1);
    bus.in_valid = 1'b0;
    restart = 1'b1;
    @(negedge clk1);
    restart = 1'b0;
    check("restart_in_ready", 32'(bus.in_ready), 32'd1);
    check("restart_cpu_hold", 32'(cpu_hold), 32'd1);
    check("restart_load_done", 32'(load_done), 32'd0);
    check("restart_load_err", 32'(load_err), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int unsigned hc;
    logic [7:0]  garbage [3];
    logic [7:0]  b;
    logic [ADDR_W-1:0] a;
    rst = 1'b1;
    restart = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = 8'd0;
    repeat (3) @(negedge clk1);
    check_reset_values("reset");
    rst = 1'b0;

    // Known frame, good checksum.
    fixed_words = '{32'h11223344, 32'h55667788, 32'hFC000000};
    run_frame(3, 1'b0, 0, -1);
    do_restart();
    // Same frame, bad checksum.
    run_frame(3, 1'b1, 0, -1);
    repeat (5) @(negedge clk1);
    check("err_in_ready_hold", 32'(bus.in_ready), 32'd0);
    do_restart();

    // Leading garbage, then an empty frame.
    garbage = '{8'h00, 8'hFF, 8'h5A};
    for (int i = 0; i < 3; i++) send_byte(garbage[i], hc);
    run_frame(0, 1'b0, 0, -1);
    do_restart();

    // Counts too large for memory.
    run_frame(MAX_N + 1, 1'b0, 0, -1);
    do_restart();
    run_frame(16'hFFFF, 1'b0, 0, -1);
    do_restart();

    // A 20-cycle stall in the middle of word 1.
    run_frame(3, 1'b0, 0, 5);
    do_restart();

    // Reset after 6 data bytes: only word 0 is written.
    send_byte(8'hA5, hc);
    send_byte(8'h00, hc);
    send_byte(8'h03, hc);
    for (int j = 0; j < 6; j++) begin
      b = 8'h10 + 8'(j);
      send_byte(b, hc);
      if (j == 3) begin
        a = ADDR_W'(BASE);
        exp_q.push_back({hc, a, 32'h10111213});
      end
    end
    @(negedge clk1);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk1);
    check_reset_values("midframe_rst");
    check("midframe_writes", 32'(exp_q.size()), 32'd0);
    rst = 1'b0;
    run_frame(3, 1'b0, 20, -1);

    // A reset in the same cycle as restart takes priority, so words_loaded is cleared.
    @(negedge clk1);
    rst = 1'b1;
    restart = 1'b1;
    @(negedge clk1);
    rst = 1'b0;
    restart = 1'b0;
    check_reset_values("rst_and_restart");

    // Random frames.
    fixed_words = {};
    for (int f = 0; f < 8; f++) begin
      run_frame($urandom_range(0, 6), 1'($urandom_range(0, 1)), 30, -1);
      do_restart();
    end

    // Largest count that fits: the top address gets written.
    run_frame(MAX_N, 1'b0, 0, -1);
    do_restart();

    idle(3);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("final dbg_state=%0d", dbg_state);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
